// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read, dual-write register file with per-register pending scoreboard
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;

    // Effective enables: nothing takes effect during reset, and register 0
    // is untouchable when it is hardwired to zero. Bypass uses these too so
    // forwarded data always matches what the array will actually hold.
    logic we0_eff;
    logic we1_eff;
    logic iss_eff;

    assign we0_eff = we0 && resetn && !(ZERO_REG != 0 && waddr0 == '0);
    assign we1_eff = we1 && resetn && !(ZERO_REG != 0 && waddr1 == '0);
    assign iss_eff = iss_valid && resetn && !(ZERO_REG != 0 && iss_addr == '0);

    // Register array update; port 1 is written last so it wins on a collision
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else begin
            if (we0_eff) regs[waddr0] <= wdata0;
            if (we1_eff) regs[waddr1] <= wdata1;
        end
    end

    // Scoreboard update; the issue is applied last so a new producer wins over a retiring write
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending <= '0;
        end else begin
            if (we0_eff)  pending[waddr0]   <= 1'b0;
            if (we1_eff)  pending[waddr1]   <= 1'b0;
            if (iss_eff)  pending[iss_addr] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              rb;
        logic              hit0;
        logic              hit1;
        logic              ihit;

        assign ra = raddr[i*ADDR_W +: ADDR_W];

        // Combinational read with optional same-cycle forwarding and busy masking
        always_comb begin
            hit0 = (BYPASS != 0) && we0_eff && (waddr0 == ra);
            hit1 = (BYPASS != 0) && we1_eff && (waddr1 == ra);
            ihit = iss_eff && (iss_addr == ra);
            rd   = regs[ra];
            rb   = pending[ra];
            if (hit1) begin
                rd = wdata1;
            end else if (hit0) begin
                rd = wdata0;
            end
            if ((hit0 || hit1) && !ihit) begin
                rb = 1'b0;
            end
            if (ZERO_REG != 0 && ra == '0) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign rdata[i*DATA_W +: DATA_W] = rd;
        assign rbusy[i]                  = rb;
    end

endmodule
